// File: rtl/tc_pl_chips_opm_pkg.sv
// Shared types and defaults for the OPM0 serial link blocks.
// Imported by the OPM write and read-back masters.
package tc_pl_chips_opm_pkg;

  localparam int OPM_ADDR_W  = 7;
  localparam int OPM_DATA_W  = 16;
  localparam int OPM_CLK_DIV = 8;

  localparam logic OPM_CMD_RD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_DATA,
    ST_HOLD,
    ST_GAP
  } opm_st_e;

endpackage

// File: rtl/tc_pl_chips_opm_sclk.sv
// Half-phase counter and SCK generator for the OPM0 link.
// SCK toggles only while i_sck_en; phase-end ticks run whenever i_en.
import tc_pl_chips_opm_pkg::*;

module tc_pl_chips_opm_sclk #(
  parameter int CLK_DIV = OPM_CLK_DIV
) (
  input  logic clk125,
  input  logic rst,
  input  logic i_en,
  input  logic i_sck_en,
  output logic o_tick_lo_end,
  output logic o_tick_hi_end,
  output logic o_sck
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;
  logic          r_sck;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else begin
      if (w_tick) r_cnt <= '0;
      else        r_cnt <= r_cnt + 1'b1;
      if (w_tick && i_sck_en) r_sck <= ~r_sck;
    end
  end

  assign o_tick_lo_end = w_tick & ~r_sck;
  assign o_tick_hi_end = w_tick &  r_sck;
  assign o_sck         = r_sck;

endmodule

// File: rtl/tc_pl_chips_opm_rd.sv
// OPM0 read-back master: SPI mode-0 register read for GP0.
// Define OPM_RD_PARITY_EN to clock and check an even parity bit.
import tc_pl_chips_opm_pkg::*;

module tc_pl_chips_opm_rd #(
  parameter int CLK_DIV = OPM_CLK_DIV,
  parameter int ADDR_W  = OPM_ADDR_W,
  parameter int DATA_W  = OPM_DATA_W
) (
  input  logic              clk125,
  input  logic              rst,
  input  logic              gp0_rq,
  input  logic [ADDR_W-1:0] gp0_rq_addr,
  output logic [DATA_W-1:0] gp0_rd_data,
  output logic              gp0_rd_vld,
  output logic              gp0_rd_busy,
  output logic              gp0_rd_err,
  output logic              OPM0_SCK,
  output logic              OPM0_CSN,
  output logic              OPM0_MOSI,
  input  logic              OPM0_MISO
);

`ifdef OPM_RD_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CMD_W = ADDR_W + 1;
  localparam int BMAX  = (NBITS > CMD_W) ? NBITS : CMD_W;
  localparam int BW    = $clog2(BMAX);

  opm_st_e           r_st;
  logic              r_start;
  logic [CMD_W-1:0]  r_cmd;
  logic [BW-1:0]     r_bit;
  logic [NBITS-1:0]  r_shin;
  logic [1:0]        r_sync;
  logic [DATA_W-1:0] r_data;
  logic              r_vld;
  logic              r_busy;
  logic              r_csn;
  logic              r_mosi;
  logic              r_err;

  logic              w_en;
  logic              w_sck_en;
  logic              w_lo_end;
  logic              w_hi_end;
  logic              w_sck;
  logic [DATA_W-1:0] w_word;
  logic              w_perr;

  assign w_en     = (r_st != ST_IDLE);
  assign w_sck_en = (r_st == ST_CMD) || (r_st == ST_DATA);

  tc_pl_chips_opm_sclk #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk125        (clk125),
    .rst           (rst),
    .i_en          (w_en),
    .i_sck_en      (w_sck_en),
    .o_tick_lo_end (w_lo_end),
    .o_tick_hi_end (w_hi_end),
    .o_sck         (w_sck)
  );

`ifdef OPM_RD_PARITY_EN
  assign w_word = r_shin[NBITS-1:1];
  assign w_perr = (^r_shin[NBITS-1:1]) ^ r_shin[0];
`else
  assign w_word = r_shin;
  assign w_perr = 1'b0;
`endif

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      r_st    <= ST_IDLE;
      r_start <= 1'b0;
      r_cmd   <= '0;
      r_bit   <= '0;
      r_shin  <= '0;
      r_sync  <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_csn   <= 1'b1;
      r_mosi  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], OPM0_MISO};
      unique case (r_st)
        ST_IDLE: begin
          if (r_start) begin
            r_start <= 1'b0;
            r_st    <= ST_SETUP;
            r_busy  <= 1'b1;
            r_csn   <= 1'b0;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
            r_mosi  <= r_cmd[CMD_W-1];
            r_bit   <= BW'(CMD_W - 1);
            r_shin  <= '0;
          end else if (gp0_rq) begin
            r_start <= 1'b1;
            r_cmd   <= {OPM_CMD_RD, gp0_rq_addr};
          end
        end
        ST_SETUP: begin
          if (w_lo_end) r_st <= ST_CMD;
        end
        ST_CMD: begin
          if (w_hi_end) begin
            // the zero shifted in lands on MOSI for the DATA phase
            r_cmd  <= {r_cmd[CMD_W-2:0], 1'b0};
            r_mosi <= r_cmd[CMD_W-2];
            if (r_bit == '0) begin
              r_st  <= ST_DATA;
              r_bit <= BW'(NBITS - 1);
            end else begin
              r_bit <= r_bit - 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_hi_end) begin
            r_shin <= {r_shin[NBITS-2:0], r_sync[1]};
            if (r_bit == '0) r_st  <= ST_HOLD;
            else             r_bit <= r_bit - 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_lo_end) begin
            r_st   <= ST_GAP;
            r_csn  <= 1'b1;
            r_vld  <= 1'b1;
            r_data <= w_word;
            r_err  <= w_perr;
          end
        end
        ST_GAP: begin
          if (w_lo_end) begin
            r_st   <= ST_IDLE;
            r_busy <= 1'b0;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign gp0_rd_data = r_data;
  assign gp0_rd_vld  = r_vld;
  assign gp0_rd_busy = r_busy;
`ifdef OPM_RD_PARITY_EN
  assign gp0_rd_err  = r_err;
`else
  assign gp0_rd_err  = 1'b0 & r_err;
`endif
  assign OPM0_SCK    = w_sck;
  assign OPM0_CSN    = r_csn;
  assign OPM0_MOSI   = r_mosi;

endmodule

// File: tb/tb_tc_pl_chips_opm_rd.sv
// Bench for tc_pl_chips_opm_rd: two instances (CLK_DIV 8 and 3)
// driven by vector tables, random frames and a SPI slave model.
module tb_tc_pl_chips_opm_rd;

`ifdef OPM_RD_PARITY_EN
  localparam int NB  = 17;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 16;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [1:0]  rq = '0;
  logic [6:0]  addr_a [2];
  logic [15:0] data_a [2];
  logic [1:0]  vld, busy, err, sck, csn, mosi;

  logic [15:0] sdata [2];
  logic        spar  [2];
  int          slv_cnt    [2];
  int          slv_frames [2];
  logic [7:0]  slv_cmd    [2];
  int          mon_bad    [2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int D = (g == 0) ? 8 : 3;
    logic       r_miso = 1'b0;
    logic       ps = 1'b0, pc = 1'b1, pm = 1'b0;
    logic       s, c, m;
    int         cnt = 0, frames = 0, mbad = 0, hrun = 0, idx;
    logic [7:0] cmd = '0;

    tc_pl_chips_opm_rd #(.CLK_DIV(D)) dut (
      .clk125      (clk),
      .rst         (rst),
      .gp0_rq      (rq[g]),
      .gp0_rq_addr (addr_a[g]),
      .gp0_rd_data (data_a[g]),
      .gp0_rd_vld  (vld[g]),
      .gp0_rd_busy (busy[g]),
      .gp0_rd_err  (err[g]),
      .OPM0_SCK    (sck[g]),
      .OPM0_CSN    (csn[g]),
      .OPM0_MOSI   (mosi[g]),
      .OPM0_MISO   (r_miso)
    );

    // values seen here are the settled ones from the previous cycle
    always @(posedge clk) begin
      s = sck[g]; c = csn[g]; m = mosi[g];
      if (c && s) begin
        mbad++;
        $display("FAIL mon%0d sck_idle sck=%b required=0 t=%0t", g, s, $time);
      end
      if (pc && !c && s) begin
        mbad++;
        $display("FAIL mon%0d csn_fall sck=%b required=0 t=%0t", g, s, $time);
      end
      if (ps && s && (m != pm)) begin
        mbad++;
        $display("FAIL mon%0d mosi_hold mosi=%b required=%b t=%0t", g, m, pm, $time);
      end
      if (s) hrun++;
      else begin
        if (ps && !c && hrun != D) begin
          mbad++;
          $display("FAIL mon%0d sck_high len=%0d required=%0d t=%0t", g, hrun, D, $time);
        end
        hrun = 0;
      end
      if (pc && !c) begin
        cnt = 0; cmd = '0; frames++;
      end else if (!c) begin
        if (!ps && s && cnt < 8) cmd = {cmd[6:0], m};
        if (ps && !s) begin
          cnt++;
          if (cnt >= 8) begin
            idx = cnt - 8;
            if (idx < 16)       r_miso <= sdata[g][15-idx];
            else if (idx == 16) r_miso <= spar[g];
            else                r_miso <= 1'b0;
          end
        end
      end
      ps = s; pc = c; pm = m;
    end

    assign slv_cnt[g]    = cnt;
    assign slv_frames[g] = frames;
    assign slv_cmd[g]    = cmd;
    assign mon_bad[g]    = mbad;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic int lat(input int sel);
    int d;
    d = (sel == 0) ? 8 : 3;
    return 1 + d * (2 + 2 * (8 + NB));
  endfunction

  task automatic run_frame(input int sel, input logic [6:0] a,
                           input logic [15:0] d, input logic pbit,
                           input logic [7:0] e_cmd, input logic [15:0] e_data,
                           input logic e_err, input string tag);
    int k, got, dv;
    dv = (sel == 0) ? 8 : 3;
    sdata[sel] = d;
    spar[sel]  = pbit;
    @(posedge clk); #1;
    rq[sel] = 1'b1;
    addr_a[sel] = a;
    @(posedge clk); #1;
    rq[sel] = 1'b0;
    k = cyc;
    @(posedge clk); #1;
    chk({tag, ".busy_k1"}, busy[sel], 1);
    chk({tag, ".vld_k1"}, vld[sel], 0);
    chk({tag, ".csn_k1"}, csn[sel], 0);
    got = 0;
    for (int n = 0; n < 3000; n++) begin
      if (vld[sel]) begin got = cyc - k; break; end
      @(posedge clk); #1;
    end
    chk({tag, ".vld_lat"}, got, lat(sel));
    chk({tag, ".data"}, data_a[sel], e_data);
    chk({tag, ".err"}, err[sel], e_err);
    chk({tag, ".csn_end"}, csn[sel], 1);
    chk({tag, ".cmd"}, slv_cmd[sel], e_cmd);
    got = 0;
    for (int n = 0; n < 100; n++) begin
      if (!busy[sel]) begin got = cyc - k; break; end
      @(posedge clk); #1;
    end
    chk({tag, ".busy_lat"}, got, lat(sel) + dv);
  endtask

  typedef struct {
    int          sel;
    logic [6:0]  addr;
    logic [15:0] sd;
    logic        flip;
    logic [7:0]  e_cmd;
    logic [15:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int f0, k, sel;
    logic [6:0] a;
    logic [15:0] d;
    logic pb, ee, seen;

    tbl[0] = '{0, 7'h15, 16'hA5C3, 1'b0, 8'h95, 16'hA5C3, 1'b0};
    tbl[1] = '{1, 7'h00, 16'hFFFF, 1'b0, 8'h80, 16'hFFFF, 1'b0};
    tbl[2] = '{1, 7'h7F, 16'h0001, 1'b0, 8'hFF, 16'h0001, 1'b0};
    tbl[3] = '{0, 7'h2A, 16'h0003, 1'b1, 8'hAA, 16'h0003, PAR};
    tbl[4] = '{0, 7'h2A, 16'h0003, 1'b0, 8'hAA, 16'h0003, 1'b0};
    tbl[5] = '{1, 7'h41, 16'h8000, 1'b0, 8'hC1, 16'h8000, 1'b0};

    for (int i = 0; i < 2; i++) begin
      addr_a[i] = '0; sdata[i] = '0; spar[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d.csn", i), csn[i], 1);
      chk($sformatf("rst%0d.sck", i), sck[i], 0);
      chk($sformatf("rst%0d.mosi", i), mosi[i], 0);
      chk($sformatf("rst%0d.vld", i), vld[i], 0);
      chk($sformatf("rst%0d.busy", i), busy[i], 0);
      chk($sformatf("rst%0d.err", i), err[i], 0);
      chk($sformatf("rst%0d.data", i), data_a[i], 0);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      pb = (^tbl[i].sd) ^ tbl[i].flip;
      run_frame(tbl[i].sel, tbl[i].addr, tbl[i].sd, pb, tbl[i].e_cmd,
                tbl[i].e_data, tbl[i].e_err, $sformatf("vec%0d", i));
    end

    // request held high for a whole frame
    f0 = slv_frames[0];
    sdata[0] = 16'h5A3C;
    spar[0]  = ^sdata[0];
    @(posedge clk); #1;
    rq[0] = 1'b1;
    addr_a[0] = 7'h33;
    seen = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      if (busy[0]) seen = 1'b1;
      else if (seen) break;
    end
    rq[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold.frames", slv_frames[0] - f0, 1);
    chk("hold.busy", busy[0], 0);
    chk("hold.vld", vld[0], 1);
    chk("hold.data", data_a[0], 16'h5A3C);
    chk("hold.cmd", slv_cmd[0], 8'hB3);
    run_frame(0, 7'h0C, 16'h1234, ^16'h1234, 8'h8C, 16'h1234, 1'b0, "after_hold");

    // reset in the middle of the data phase
    sdata[0] = 16'hBEEF;
    spar[0]  = ^sdata[0];
    @(posedge clk); #1;
    rq[0] = 1'b1;
    addr_a[0] = 7'h55;
    @(posedge clk); #1;
    rq[0] = 1'b0;
    k = 0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      if (slv_cnt[0] == 18 && !csn[0]) begin k = 1; break; end
    end
    chk("abort.reach_bit10", k, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort.csn", csn[0], 1);
    chk("abort.sck", sck[0], 0);
    chk("abort.vld", vld[0], 0);
    chk("abort.busy", busy[0], 0);
    chk("abort.data", data_a[0], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(0, 7'h15, 16'hA5C3, ^16'hA5C3, 8'h95, 16'hA5C3, 1'b0, "post_abort");

    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 1));
      a   = 7'($urandom);
      d   = 16'($urandom);
      pb  = (^d) ^ (PAR & 1'($urandom_range(0, 1)));
      ee  = PAR && (pb != (^d));
      run_frame(sel, a, d, pb, {1'b1, a}, d, ee, $sformatf("rnd%0d", i));
    end

    repeat (4) @(posedge clk);
    chk("mon0.violations", mon_bad[0], 0);
    chk("mon1.violations", mon_bad[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
